pipe_shell: RTL and testbench

PIPE_SHELL -- requirements
Module: pipe_shell

---
 rtl/pipe_shell.sv | 125 ++++++++++++
 tb/tb_pipe_shell.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_shell.sv
// rtl/pipe_shell.sv - stallable/squashable pipeline shell; counters gated by PIPE_SHELL_PERF_CNT_EN
module pipe_shell #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 4,
  parameter int HOLD_STAGE    = 1,
  parameter int SQUASH_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             stall,
  input  logic             hazard,
  input  logic             squash,
  output logic [DEPTH-1:0] stage_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt,
  output logic [31:0]      squash_cnt
);

  // Stage registers; stage 0 is youngest, stage DEPTH-1 drives the output.
  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  // What each stage would load on a plain advance.
  logic             w_accept;
  logic [DEPTH-1:0] w_src_valid;
  logic [WIDTH-1:0] w_src_data [DEPTH];

  assign in_ready = ~stall & ~hazard & ~squash;
  assign w_accept = in_valid & in_ready;

  // Advance sources: stage 0 takes the accepted input (zero data when nothing
  // is accepted, so empty stages stay deterministic), stage k takes stage k-1.
  always_comb begin
    w_src_valid[0] = w_accept;
    w_src_data[0]  = w_accept ? in_data : '0;
    for (int k = 1; k < DEPTH; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_data[k]  = r_data[k-1];
    end
  end

  // Stage update with priority stall > squash > hazard > normal advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (squash) begin
          // Youngest SQUASH_STAGES are cleared, the rest keep draining.
          if (k < SQUASH_STAGES) begin
            r_valid[k] <= 1'b0;
            r_data[k]  <= '0;
          end else begin
            r_valid[k] <= w_src_valid[k];
            r_data[k]  <= w_src_data[k];
          end
        end else if (hazard) begin
          // Stages below HOLD_STAGE freeze, HOLD_STAGE takes a bubble.
          if (k == HOLD_STAGE) begin
            r_valid[k] <= 1'b0;
            r_data[k]  <= '0;
          end else if (k > HOLD_STAGE) begin
            r_valid[k] <= w_src_valid[k];
            r_data[k]  <= w_src_data[k];
          end
        end else begin
          r_valid[k] <= w_src_valid[k];
          r_data[k]  <= w_src_data[k];
        end
      end
    end
  end

  assign stage_valid = r_valid;
  assign out_valid   = r_valid[DEPTH-1];
  assign out_data    = r_data[DEPTH-1];

`ifdef PIPE_SHELL_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_squash_cnt;
  logic        w_do_squash;
  logic        w_do_hazard;

  // Only the winning control of a cycle is counted.
  assign w_do_squash = ~stall & squash;
  assign w_do_hazard = ~stall & ~squash & hazard;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_squash_cnt <= '0;
    end else begin
      if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_do_hazard && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if (w_do_squash && (r_squash_cnt != 32'hFFFF_FFFF)) begin
        r_squash_cnt <= r_squash_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign squash_cnt = r_squash_cnt;
`else
  assign stall_cnt  = 32'd0;
  assign bubble_cnt = 32'd0;
  assign squash_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_shell.sv
// tb/tb_pipe_shell.sv - randomized and directed bench for pipe_shell against a queue model
module tb_pipe_shell;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int HS = 1;
  localparam int SQ = 3;
`ifdef PIPE_SHELL_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         stall = 1'b0;
  logic         hazard = 1'b0;
  logic         squash = 1'b0;
  logic         in_ready;
  logic [D-1:0] stage_valid;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [31:0]  stall_cnt;
  logic [31:0]  bubble_cnt;
  logic [31:0]  squash_cnt;

  pipe_shell #(.WIDTH(W), .DEPTH(D), .HOLD_STAGE(HS), .SQUASH_STAGES(SQ)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall(stall), .hazard(hazard), .squash(squash), .stage_valid(stage_valid),
    .out_valid(out_valid), .out_data(out_data), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queue of slots {valid, data}, index 0 = youngest; a bubble is all zero.
  logic [W:0] pipe[$];
  int m_stall, m_bubble, m_squash;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pipe.delete();
    for (int k = 0; k < D; k++) pipe.push_back('0);
    m_stall = 0; m_bubble = 0; m_squash = 0;
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] d,
                            input logic st, input logic hz, input logic sq);
    logic [W:0] nq[$];
    if (st) begin
      m_stall++;
    end else if (sq) begin
      pipe.push_front('0);
      void'(pipe.pop_back());
      for (int k = 0; k < SQ; k++) pipe[k] = '0;
      m_squash++;
    end else if (hz) begin
      nq = {};
      for (int k = 0; k < HS; k++) nq.push_back(pipe[k]);
      nq.push_back('0);
      for (int k = HS; k < D - 1; k++) nq.push_back(pipe[k]);
      pipe = nq;
      m_bubble++;
    end else begin
      pipe.push_front(v ? {1'b1, d} : '0);
      void'(pipe.pop_back());
    end
  endtask

  function automatic logic [D-1:0] model_sv();
    logic [D-1:0] r;
    for (int k = 0; k < D; k++) r[k] = pipe[k][W];
    return r;
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic check_outputs(input string where);
    chk({where, ".stage_valid"}, 64'(stage_valid), 64'(model_sv()));
    chk({where, ".out_valid"}, 64'(out_valid), 64'(pipe[D-1][W]));
    chk({where, ".out_data"}, 64'(out_data), 64'(pipe[D-1][W-1:0]));
    chk({where, ".stall_cnt"}, 64'(stall_cnt), 64'(exp_cnt(m_stall)));
    chk({where, ".bubble_cnt"}, 64'(bubble_cnt), 64'(exp_cnt(m_bubble)));
    chk({where, ".squash_cnt"}, 64'(squash_cnt), 64'(exp_cnt(m_squash)));
  endtask

  // One clock: drive, check in_ready, take the edge, check against the model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic st,
                      input logic hz, input logic sq, input string where);
    in_valid = v; in_data = d; stall = st; hazard = hz; squash = sq;
    #1;
    chk({where, ".in_ready"}, 64'(in_ready), 64'(!(st || hz || sq)));
    @(posedge clk);
    model_edge(v, d, st, hz, sq);
    #1;
    check_outputs(where);
  endtask

  // Asynchronous reset away from the edge; an offer during reset is discarded.
  task automatic do_reset(input logic st_during);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; stall = st_during; hazard = 1'b0; squash = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    check_outputs("rst");
    chk("rst.in_ready", 64'(in_ready), 64'(!st_during));
    @(posedge clk);
    #1;
    check_outputs("rst_edge");
    rst = 1'b1;
    in_valid = 1'b0; stall = 1'b0;
  endtask

  initial begin
    model_clear();
    do_reset(1'b0);

    // Latency: three back-to-back pushes emerge on steps 4,5,6.
    for (int i = 1; i <= 7; i++) begin
      step(i <= 3, (i == 1) ? 32'h11 : (i == 2) ? 32'h22 : 32'h33, 1'b0, 1'b0, 1'b0, "lat");
      if (i == 4) chk("lat.first", 64'({out_valid, out_data}), 64'({1'b1, 32'h11}));
      if (i == 5) chk("lat.second", 64'({out_valid, out_data}), 64'({1'b1, 32'h22}));
      if (i == 6) chk("lat.third", 64'({out_valid, out_data}), 64'({1'b1, 32'h33}));
      if (i == 7) chk("lat.drained", 64'(out_valid), 64'(1'b0));
    end

    // Full pipe A..D, stall three cycles, then resume.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i) * 32'h10, 1'b0, 1'b0, 1'b0, "fill");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h99, 1'b1, 1'b0, 1'b0, "stall");
      chk("stall.full", 64'(stage_valid), 64'(4'hF));
      chk("stall.frozen", 64'(out_data), 64'(32'hA0));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0, 1'b0, "resume");
      chk("resume.order", 64'(out_data), 64'(32'hB0 + 32'(i) * 32'h10));
    end

    // One-cycle hazard on a full pipe.
    step(1'b1, 32'h55, 1'b0, 1'b1, 1'b0, "hazard");
    chk("hazard.bubble", 64'(stage_valid), 64'(4'b1101));
    for (int i = 0; i < 5; i++) step(1'b1, 32'h60 + 32'(i), 1'b0, 1'b0, 1'b0, "post_hz");

    // Squash with stages 0-2 holding X,Y,Z (Z oldest).
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "drain");
    step(1'b1, 32'h5A, 1'b0, 1'b0, 1'b0, "pushZ");
    step(1'b1, 32'h59, 1'b0, 1'b0, 1'b0, "pushY");
    step(1'b1, 32'h58, 1'b0, 1'b0, 1'b0, "pushX");
    step(1'b1, 32'h77, 1'b0, 1'b0, 1'b1, "squash");
    chk("squash.valid", 64'(stage_valid), 64'(4'b1000));
    chk("squash.out", 64'(out_data), 64'(32'h5A));
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "post_sq");

    // Stall wins over squash.
    step(1'b1, 32'h31, 1'b0, 1'b0, 1'b0, "pre_ss");
    step(1'b1, 32'h32, 1'b1, 1'b0, 1'b1, "stall_squash");
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "post_ss");

    // Counter scenario from a clean reset; reset also asserted under stall.
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h40 + 32'(i), 1'b1, 1'b0, 1'b0, "cnt_stall");
    for (int i = 0; i < 2; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 1'b1, 1'b0, "cnt_hz");
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "cnt_sq");
    chk("cnt.stall", 64'(stall_cnt), 64'(CNT_EN ? 32'd5 : 32'd0));
    chk("cnt.bubble", 64'(bubble_cnt), 64'(CNT_EN ? 32'd2 : 32'd0));
    chk("cnt.squash", 64'(squash_cnt), 64'(CNT_EN ? 32'd1 : 32'd0));

    // Random traffic with a mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1'b0);
      step(($urandom % 4) != 0, $urandom, ($urandom % 8) == 0,
           ($urandom % 6) == 0, ($urandom % 10) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
